// File: rtl/light_follower_queue_if.sv
// rtl/light_follower_queue_if.sv - light/time bus and queue status signals between light controller and follower queue
interface light_follower_queue_if #(
  parameter int QW = 8
);
  logic [1:0]    light_sign;
  logic [7:0]    time_left;
  logic          car_arrive;
  logic          car_depart;
  logic [QW-1:0] queue_count;
  logic [1:0]    go_state;
  logic          seq_error;
  logic          overflow;
  logic          time_error;

  modport master (
    output light_sign, time_left, car_arrive,
    input  car_depart, queue_count, go_state, seq_error, overflow, time_error
  );

  modport slave (
    input  light_sign, time_left, car_arrive,
    output car_depart, queue_count, go_state, seq_error, overflow, time_error
  );
endinterface

// File: rtl/light_follower_queue.sv
// rtl/light_follower_queue.sv - stop-line vehicle queue with light sequence checker; TIME_CHECK_EN adds countdown checking
module light_follower_queue #(
  parameter int QW         = 8,
  parameter int HEADWAY    = 4,
  parameter int YELLOW_MIN = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   src_reset,
  light_follower_queue_if.slave  bus
);
  localparam logic [1:0] HOLD   = 2'd0;
  localparam logic [1:0] READY  = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  localparam logic [1:0] L_RED    = 2'd0;
  localparam logic [1:0] L_GREEN  = 2'd1;
  localparam logic [1:0] L_YELLOW = 2'd2;
  localparam logic [1:0] L_BAD    = 2'd3;

  localparam logic [QW-1:0] QMAX     = '1;
  localparam int            GW       = (HEADWAY > 1) ? $clog2(HEADWAY) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(HEADWAY - 1);
  localparam logic [7:0]    YMIN     = 8'(YELLOW_MIN);

  logic [1:0]    state;
  logic [1:0]    prev_light;
  logic          armed;
  logic [GW-1:0] gap_cnt;
  logic [QW-1:0] count;
  logic          depart_q;
  logic          seq_err_q;
  logic          ovf_q;

  logic check_en;
  logic legal_step;
  logic seq_viol;
  logic block;
  logic permit;
  logic depart_now;

  // The checker is blind while the controller itself is held in reset.
  assign check_en   = armed && !src_reset;
  assign legal_step = (bus.light_sign == prev_light)
                   || (prev_light == L_RED    && bus.light_sign == L_GREEN)
                   || (prev_light == L_GREEN  && bus.light_sign == L_YELLOW)
                   || (prev_light == L_YELLOW && bus.light_sign == L_RED);
  assign seq_viol   = check_en && (bus.light_sign == L_BAD || !legal_step);
  assign block      = seq_err_q || seq_viol;
  assign permit     = !block && (bus.light_sign == L_GREEN
                    || (bus.light_sign == L_YELLOW && bus.time_left >= YMIN));
  assign depart_now = (state == READY) && permit && (count != '0);

  always_ff @(posedge clk) begin
    prev_light <= bus.light_sign;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HOLD;
      armed     <= 1'b0;
      gap_cnt   <= '0;
      count     <= '0;
      depart_q  <= 1'b0;
      seq_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      armed    <= !src_reset;
      depart_q <= depart_now;
      if (seq_viol)
        seq_err_q <= 1'b1;

      // Simultaneous arrival and departure nets to zero, even when full.
      if (bus.car_arrive && !depart_now && count == QMAX)
        ovf_q <= 1'b1;
      else
        count <= count + QW'(bus.car_arrive) - QW'(depart_now);

      case (state)
        HOLD: begin
          if (permit)
            state <= READY;
        end
        READY: begin
          if (!permit) begin
            state <= HOLD;
          end else if (count != '0) begin
            if (HEADWAY == 1) begin
              state <= READY;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (block) begin
            state   <= HOLD;
            gap_cnt <= '0;
          end else if (gap_cnt <= GW'(1)) begin
            state   <= permit ? READY : HOLD;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  assign bus.car_depart  = depart_q;
  assign bus.queue_count = count;
  assign bus.go_state    = state;
  assign bus.seq_error   = seq_err_q;
  assign bus.overflow    = ovf_q;

`ifdef TIME_CHECK_EN
  logic [7:0] prev_time;
  logic       time_err_q;
  logic       time_viol;

  // Unchanged light must count down by one; a light change must land on expiry.
  assign time_viol = check_en && ((bus.light_sign == prev_light)
                   ? !(prev_time != 8'd0 && bus.time_left == prev_time - 8'd1)
                   : (prev_time != 8'd0));

  always_ff @(posedge clk) begin
    prev_time <= bus.time_left;
    if (reset)
      time_err_q <= 1'b0;
    else if (time_viol)
      time_err_q <= 1'b1;
  end

  assign bus.time_error = time_err_q;
`else
  assign bus.time_error = 1'b0;
`endif
endmodule

// File: tb/tb_light_follower_queue.sv
// tb/tb_light_follower_queue.sv - directed self-checking bench for light_follower_queue
module tb_light_follower_queue;
  logic clk = 1'b0;
  logic reset;
  logic src_reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  light_follower_queue_if #(.QW(8)) bus_a ();
  light_follower_queue_if #(.QW(2)) bus_b ();

  light_follower_queue #(.QW(8), .HEADWAY(4), .YELLOW_MIN(2)) dut_a (
    .clk(clk), .reset(reset), .src_reset(src_reset), .bus(bus_a)
  );
  light_follower_queue #(.QW(2), .HEADWAY(4), .YELLOW_MIN(2)) dut_b (
    .clk(clk), .reset(reset), .src_reset(src_reset), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic       t2_dep [14] = '{0,1,0,0,0,1,0,0,0,1,0,0,0,0};
  logic [7:0] t2_q   [14] = '{3,2,2,2,2,1,1,1,1,0,0,0,0,0};

  initial begin
    reset = 1'b1;
    src_reset = 1'b0;
    bus_a.light_sign = 2'd0; bus_a.time_left = 8'd0; bus_a.car_arrive = 1'b0;
    bus_b.light_sign = 2'd0; bus_b.time_left = 8'd0; bus_b.car_arrive = 1'b0;
    tick(); tick();
    check("rst_depart", bus_a.car_depart, 0);
    check("rst_queue", bus_a.queue_count, 0);
    check("rst_state", bus_a.go_state, 0);
    check("rst_seq", bus_a.seq_error, 0);
    check("rst_ovf", bus_a.overflow, 0);
    check("rst_time", bus_a.time_error, 0);

    // 1: arrivals on RED queue up, nothing departs
    reset = 1'b0;
    bus_a.car_arrive = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_queue", bus_a.queue_count, i + 1);
      check("t1_depart", bus_a.car_depart, 0);
    end
    bus_a.car_arrive = 1'b0;
    check("t1_state", bus_a.go_state, 0);

    // 2: GREEN drains three cars four cycles apart
    bus_a.light_sign = 2'd1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("t2_depart", bus_a.car_depart, t2_dep[i]);
      check("t2_queue", bus_a.queue_count, t2_q[i]);
      if (i == 0) check("t2_ready", bus_a.go_state, 1);
      if (i == 1) check("t2_gap", bus_a.go_state, 2);
    end
    check("t2_idle", bus_a.go_state, 1);

    // 3: YELLOW departures only while time_left >= 2
    reset = 1'b1;
    bus_a.light_sign = 2'd2; bus_a.time_left = 8'd0;
    tick();
    reset = 1'b0;
    bus_a.car_arrive = 1'b1;
    repeat (5) tick();
    bus_a.car_arrive = 1'b0;
    check("t3_load", bus_a.queue_count, 5);
    check("t3_hold0", bus_a.go_state, 0);
    bus_a.time_left = 8'd3; tick();
    check("t3_ready", bus_a.go_state, 1);
    bus_a.time_left = 8'd2; tick();
    check("t3_dep", bus_a.car_depart, 1);
    check("t3_q4", bus_a.queue_count, 4);
    bus_a.time_left = 8'd1; tick();
    check("t3_nodep1", bus_a.car_depart, 0);
    bus_a.time_left = 8'd0; tick(); tick();
    check("t3_hold", bus_a.go_state, 0);
    bus_a.time_left = 8'd1; tick();
    check("t3_hold_t1", bus_a.go_state, 0);
    check("t3_q_kept", bus_a.queue_count, 4);
    bus_a.time_left = 8'd2; tick();
    check("t3_ready_t2", bus_a.go_state, 1);
    // reset in the decision cycle cancels the pending departure
    reset = 1'b1; tick();
    check("t3_rst_dep", bus_a.car_depart, 0);
    check("t3_rst_q", bus_a.queue_count, 0);
    check("t3_rst_state", bus_a.go_state, 0);

    // 4: GREEN -> RED is illegal; latch error and freeze departures
    bus_a.light_sign = 2'd0; bus_a.time_left = 8'd0;
    tick();
    reset = 1'b0;
    bus_a.car_arrive = 1'b1;
    repeat (4) tick();
    bus_a.car_arrive = 1'b0;
    bus_a.light_sign = 2'd1;
    tick(); tick();
    check("t4_dep", bus_a.car_depart, 1);
    check("t4_seq0", bus_a.seq_error, 0);
    bus_a.light_sign = 2'd0; tick();
    check("t4_seq1", bus_a.seq_error, 1);
    check("t4_hold", bus_a.go_state, 0);
    bus_a.light_sign = 2'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4_nodep", bus_a.car_depart, 0);
      check("t4_sticky", bus_a.seq_error, 1);
    end
    check("t4_q", bus_a.queue_count, 3);
    check("t4_state", bus_a.go_state, 0);

    // 5: QW=2 saturates at 3; arrive+depart nets to zero
    reset = 1'b1; tick();
    reset = 1'b0;
    bus_b.car_arrive = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_queue", bus_b.queue_count, (i < 3) ? i + 1 : 3);
      check("t5_ovf", bus_b.overflow, (i == 3) ? 1 : 0);
    end
    bus_b.car_arrive = 1'b0;
    bus_b.light_sign = 2'd1; tick();
    check("t5_ready", bus_b.go_state, 1);
    bus_b.car_arrive = 1'b1; tick();
    check("t5_dep", bus_b.car_depart, 1);
    check("t5_q_same", bus_b.queue_count, 3);
    bus_b.car_arrive = 1'b0; tick();
    check("t5_q_after", bus_b.queue_count, 3);
    check("t5_ovf_sticky", bus_b.overflow, 1);

    // 6: countdown checking with src_reset re-arm
    reset = 1'b1;
    bus_a.light_sign = 2'd1; bus_a.time_left = 8'd12;
    tick();
    reset = 1'b0;
    bus_a.time_left = 8'd11; tick();
    bus_a.time_left = 8'd10; tick();
    check("t6_ok", bus_a.time_error, 0);
    src_reset = 1'b1; bus_a.time_left = 8'd50; tick();
    src_reset = 1'b0; bus_a.time_left = 8'd49; tick();
    bus_a.time_left = 8'd48; tick();
    check("t6_rearm", bus_a.time_error, 0);
    check("t6_seq", bus_a.seq_error, 0);
    bus_a.time_left = 8'd46; tick();
`ifdef TIME_CHECK_EN
    check("t6_jump", bus_a.time_error, 1);
`else
    check("t6_jump", bus_a.time_error, 0);
`endif
    tick();
    check("t6_fsm", bus_a.go_state, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
